// File: rtl/core_completion_monitor.sv
// Completion monitor for the four-core processor: tracks ENDOP per core, run length and finish skew.
// Optional watchdog enabled by defining MONITOR_WATCHDOG_EN; without it timeout stays 0.
module core_completion_monitor #(
    parameter logic [7:0]  ENDOP_CODE     = 8'd122,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned DRAIN_CYCLES   = 5,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       ins1,
    input  logic [7:0]       ins2,
    input  logic [7:0]       ins3,
    input  logic [7:0]       ins4,
    output logic [3:0]       core_done,
    output logic             all_done,
    output logic             timeout,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] skew
);

    localparam int unsigned DRN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

    if (DRAIN_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("core_completion_monitor: DRAIN_CYCLES must be >=1 and TIMEOUT_CYCLES >=2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       core_done_q, core_done_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] first_q, first_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] skew_q, skew_d;
    logic [DRN_W-1:0] drain_q, drain_d;
    logic             all_done_q, all_done_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;

    logic [3:0]       hit;
    logic [3:0]       done_next;
    logic             wd_hit;

    // Only first-time ENDOPs count; repeats after a core's flag is set are masked.
    assign hit = {ins4 == ENDOP_CODE, ins3 == ENDOP_CODE,
                  ins2 == ENDOP_CODE, ins1 == ENDOP_CODE} & ~core_done_q;
    assign done_next = core_done_q | hit;

`ifdef MONITOR_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    assign wd_hit = (cycle_count_q == WD_LAST);
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        core_done_d   = core_done_q;
        cycle_count_d = cycle_count_q;
        first_d       = first_q;
        last_d        = last_q;
        skew_d        = skew_q;
        drain_d       = drain_q;

        case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start) begin
                    state_d       = S_RUN;
                    core_done_d   = '0;
                    cycle_count_d = '0;
                    first_d       = '0;
                    last_d        = '0;
                    skew_d        = '0;
                    drain_d       = '0;
                end
            end
            S_RUN: begin
                core_done_d = done_next;
                if (core_done_q == '0 && hit != '0) begin
                    first_d = cycle_count_q;
                end
                // Completion takes priority over a watchdog expiry in the same cycle.
                if (&done_next) begin
                    last_d  = cycle_count_q;
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else if (wd_hit) begin
                    state_d = S_TIMEOUT;
                end else if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRN_W'(DRAIN_CYCLES - 1)) begin
                    state_d = S_DONE;
                    skew_d  = last_q - first_q;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
        all_done_d = (state_d == S_DONE);
        timeout_d  = (state_d == S_TIMEOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            core_done_q   <= '0;
            cycle_count_q <= '0;
            first_q       <= '0;
            last_q        <= '0;
            skew_q        <= '0;
            drain_q       <= '0;
            all_done_q    <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            core_done_q   <= core_done_d;
            cycle_count_q <= cycle_count_d;
            first_q       <= first_d;
            last_q        <= last_d;
            skew_q        <= skew_d;
            drain_q       <= drain_d;
            all_done_q    <= all_done_d;
            timeout_q     <= timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign core_done   = core_done_q;
    assign all_done    = all_done_q;
    assign timeout     = timeout_q;
    assign busy        = busy_q;
    assign cycle_count = cycle_count_q;
    assign skew        = skew_q;

endmodule

// File: tb/tb_core_completion_monitor.sv
// Bench for core_completion_monitor: per-run finish times feed an arithmetic model of expected status.
module tb_core_completion_monitor;

    localparam logic [7:0]  ENDOP = 8'd122;
    localparam int unsigned DRAIN = 5;
    localparam int unsigned TMO   = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  ins_v [4];
    logic [3:0]  core_done;
    logic        all_done;
    logic        timeout;
    logic        busy;
    logic [31:0] cycle_count;
    logic [31:0] skew;

    int total = 0;
    int bad   = 0;
    int f [4];

    core_completion_monitor #(
        .ENDOP_CODE     (ENDOP),
        .CNT_W          (32),
        .DRAIN_CYCLES   (DRAIN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ins1        (ins_v[0]),
        .ins2        (ins_v[1]),
        .ins3        (ins_v[2]),
        .ins4        (ins_v[3]),
        .core_done   (core_done),
        .all_done    (all_done),
        .timeout     (timeout),
        .busy        (busy),
        .cycle_count (cycle_count),
        .skew        (skew)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    function automatic logic [7:0] non_endop();
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        if (v == ENDOP) v = 8'd0;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string ph, input logic [3:0] cd, input logic ad, input logic to,
                           input logic bz, input bit use_cc, input logic [31:0] cc,
                           input logic [31:0] sk);
        chk({ph, ".core_done"}, 64'(core_done), 64'(cd));
        chk({ph, ".all_done"},  64'(all_done),  64'(ad));
        chk({ph, ".timeout"},   64'(timeout),   64'(to));
        chk({ph, ".busy"},      64'(busy),      64'(bz));
        if (use_cc) chk({ph, ".cycle_count"}, 64'(cycle_count), 64'(cc));
        chk({ph, ".skew"},      64'(skew),      64'(sk));
    endtask

    task automatic noise_all();
        for (int i = 0; i < 4; i++) ins_v[i] = ($urandom_range(0, 1) == 1) ? ENDOP : non_endop();
    endtask

    task automatic do_reset(input string ph);
        rst = 1'b1;
        #1;
        chk_out(ph, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        rst = 1'b0;
        #1;
    endtask

    // One monitored run with finish counts f[] (-1 = core never finishes).
    task automatic run_case(input string nm, input int limit, input bit rst_in_drain);
        int         first, last, endc;
        bit         complete, tmo;
        logic [3:0] exp_cd;
        first = 1 << 30; last = -1; complete = 1'b1; tmo = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (f[i] < 0) complete = 1'b0;
            else begin
                if (f[i] < first) first = f[i];
                if (f[i] > last)  last  = f[i];
            end
        end
        endc = complete ? last : -1;
`ifdef MONITOR_WATCHDOG_EN
        if (!complete || last > int'(TMO) - 1) begin
            tmo  = 1'b1;
            endc = int'(TMO) - 1;
        end
`endif
        start = 1'b1;
        noise_all();
        @(posedge clk); #1;
        chk_out({nm, ".start"}, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0);

        for (int c = 0; (endc >= 0) ? (c <= endc) : (c < limit); c++) begin
            start = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                if (f[i] == c) ins_v[i] = ENDOP;
                else if (f[i] >= 0 && c > f[i] && $urandom_range(0, 1) == 1) ins_v[i] = ENDOP;
                else ins_v[i] = non_endop();
            end
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) exp_cd[i] = (f[i] >= 0 && f[i] <= c);
            if (tmo && c == endc)
                chk_out({nm, ".timeout"}, exp_cd, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
            else if (c == endc)
                chk_out({nm, ".final"}, exp_cd, 1'b0, 1'b0, 1'b1, 1'b1, 32'(c), 32'd0);
            else
                chk_out({nm, ".run"}, exp_cd, 1'b0, 1'b0, 1'b1, 1'b1, 32'(c + 1), 32'd0);
        end

        if (endc < 0) begin
            do_reset({nm, ".abort"});
            return;
        end

        if (!tmo) begin
            for (int j = 1; j <= int'(DRAIN); j++) begin
                start = 1'($urandom_range(0, 1));
                noise_all();
                if (rst_in_drain && j == 2) begin
                    do_reset({nm, ".drain_rst"});
                    return;
                end
                @(posedge clk); #1;
                chk_out({nm, ".drain"}, 4'b1111, 1'(j == int'(DRAIN)), 1'b0, 1'(j < int'(DRAIN)),
                        1'b1, 32'(last), (j == int'(DRAIN)) ? 32'(last - first) : 32'd0);
            end
        end

        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            noise_all();
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) exp_cd[i] = (f[i] >= 0 && f[i] <= endc);
            chk_out({nm, ".hold"}, exp_cd, ~tmo, tmo, 1'b0, 1'b0, 32'd0,
                    tmo ? 32'd0 : 32'(last - first));
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) ins_v[i] = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) ins_v[i] = ENDOP;
            @(posedge clk); #1;
            chk_out("idle_endop", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        end

        f = '{10, 10, 25, 40};
        run_case("staggered", 0, 1'b0);
        f = '{7, 7, 7, 7};
        run_case("together", 0, 1'b0);
        f = '{0, 3, 3, 9};
        run_case("first_cycle", 0, 1'b0);
`ifdef MONITOR_WATCHDOG_EN
        f = '{3, 9, 20, -1};
        run_case("wd_fire", 0, 1'b0);
        f = '{3, 9, 20, 49};
        run_case("wd_edge", 0, 1'b0);
`endif
        f = '{2, 4, 6, 8};
        run_case("drain_rst", 0, 1'b1);
        f = '{1, 5, 3, 12};
        run_case("after_rst", 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) f[i] = int'($urandom_range(0, 60));
            run_case($sformatf("rand%0d", r), 0, 1'b0);
        end

        f = '{5, 8, -1, 12};
        run_case("silent_core3", 3000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
